instruction_sequencer: RTL and testbench

Program-driven controller for the Excutor datapath. It holds a small program store of 20-bit opcodes and issues them one at a time on OpCode. Each instruction is handshaked with the executor's Done signal. The block replaces bench-driven opcode feeding, so a program runs autonomously from a Start pulse until an end opcode, the program length, or Stop.

---
 rtl/instruction_sequencer_if.sv | 36 +++
 rtl/instruction_sequencer.sv | 166 ++++++++++++++++
 tb/tb_instruction_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// Handshake/bus bundle between the instruction sequencer and its environment.
// STEP_EN adds the single-step controls (StepMode, Step).
interface instruction_sequencer_if #(
  parameter int OPW = 20,
  parameter int AW  = 5
);
  logic            Start;
  logic            Stop;
  logic            ProgWrite;
  logic [AW-1:0]   ProgAddr;
  logic [OPW-1:0]  ProgData;
  logic [AW:0]     ProgLength;
  logic            ExecDone;
  logic [OPW-1:0]  OpCode;
  logic [AW:0]     Pc;
  logic            Running;
  logic            Halted;
  logic            Error;
  logic [15:0]     InstrCount;
`ifdef STEP_EN
  logic            StepMode;
  logic            Step;
`endif

  modport master (
    input  `ifdef STEP_EN StepMode, Step, `endif
           Start, Stop, ProgWrite, ProgAddr, ProgData, ProgLength, ExecDone,
    output OpCode, Pc, Running, Halted, Error, InstrCount
  );

  modport slave (
    output `ifdef STEP_EN StepMode, Step, `endif
           Start, Stop, ProgWrite, ProgAddr, ProgData, ProgLength, ExecDone,
    input  OpCode, Pc, Running, Halted, Error, InstrCount
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Program-driven opcode issuer for the Excutor datapath: runs a stored program
// from Start until an end opcode, the program length, Stop or an accept timeout.
// Optional STEP_EN macro adds StepMode/Step and a PAUSE state between instructions.
module instruction_sequencer #(
  parameter int OPW     = 20,
  parameter int AW      = 5,
  parameter int TIMEOUT = 255
) (
  input logic                     Clock,
  input logic                     Reset,
  instruction_sequencer_if.master bus
);
  localparam int          TW    = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_EXEC, S_HALT
`ifdef STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [AW:0]    pc_q, pc_d, pc_inc;
  logic [AW:0]    len_q, len_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           pend_q, pend_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           ph_q, ph_d;
  logic           run_q, run_d;
  logic           halt_q, halt_d;
  logic [OPW-1:0] rdata_q, rdata_d;
  logic           wr_ok;

  logic [OPW-1:0] mem [2**AW];

  // Store is writable only while no program is running.
  assign wr_ok = (state_q == S_IDLE) || (state_q == S_HALT);

  always_comb begin
    rdata_d = mem[pc_q[AW-1:0]];
  end

  always_ff @(posedge Clock) begin
    if (bus.ProgWrite && wr_ok) mem[bus.ProgAddr] <= bus.ProgData;
    rdata_q <= rdata_d;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pend_d  = pend_q;
    tmo_d   = tmo_q;
    ph_d    = 1'b0;
    pc_inc  = pc_q + 1'b1;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.Start) begin
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          pend_d  = 1'b0;
          op_d    = '0;
          len_d   = (bus.ProgLength > DEPTH) ? DEPTH : bus.ProgLength;
          state_d = (bus.ProgLength == '0) ? S_HALT : S_FETCH;
        end
      end
      // Two cycles: address the store, then act on the registered word.
      S_FETCH: begin
        if (bus.Stop) pend_d = 1'b1;
        if (!ph_q) begin
          ph_d = 1'b1;
        end else if (rdata_q == '0) begin
          op_d    = '0;
          state_d = S_HALT;
        end else begin
          op_d    = rdata_q;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.Stop) pend_d = 1'b1;
        if (!bus.ExecDone) begin
          state_d = S_EXEC;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          op_d    = '0;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (bus.Stop) pend_d = 1'b1;
        if (bus.ExecDone) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 1'b1;
          pc_d = pc_inc;
          op_d = '0;
          // A Stop arriving on the completion cycle is honoured right away.
          if (pend_q || bus.Stop || (pc_inc == len_q)) state_d = S_HALT;
`ifdef STEP_EN
          else if (bus.StepMode)                       state_d = S_PAUSE;
`endif
          else                                         state_d = S_FETCH;
        end
      end
`ifdef STEP_EN
      S_PAUSE: begin
        if (bus.Stop)      state_d = S_HALT;
        else if (bus.Step) state_d = S_FETCH;
      end
`endif
      default: begin
        op_d    = '0;
        state_d = S_IDLE;
      end
    endcase
    run_d  = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_EXEC);
`ifdef STEP_EN
    run_d  = run_d || (state_d == S_PAUSE);
`endif
    halt_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      tmo_q   <= '0;
      ph_q    <= 1'b0;
      run_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      ph_q    <= ph_d;
      run_q   <= run_d;
      halt_q  <= halt_d;
    end
  end

  assign bus.OpCode     = op_q;
  assign bus.Pc         = pc_q;
  assign bus.Running    = run_q;
  assign bus.Halted     = halt_q;
  assign bus.Error      = err_q;
  assign bus.InstrCount = cnt_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: walks each program at instruction level to derive the
// expected outputs every cycle, with randomized executor timing, Stop and stray writes.
module tb_instruction_sequencer;
  localparam int OPW = 20, AW = 5, TIMEOUT = 255, DEPTH = 32;

  logic Clock = 1'b0;
  logic Reset;

  instruction_sequencer_if #(.OPW(OPW), .AW(AW)) bus();
  instruction_sequencer #(.OPW(OPW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int             checks = 0, errors = 0;
  bit             chk_en = 0;
  logic [OPW-1:0] prog [DEPTH];
  logic [OPW-1:0] exp_op;
  int             exp_pc, exp_cnt;
  bit             exp_run, exp_halt, exp_err;
  bit             step_mode = 0;
  bit             saw55 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge Clock);
    if (chk_en) begin
      chk("OpCode",     bus.OpCode,     exp_op);
      chk("Pc",         bus.Pc,         exp_pc);
      chk("Running",    bus.Running,    exp_run);
      chk("Halted",     bus.Halted,     exp_halt);
      chk("Error",      bus.Error,      exp_err);
      chk("InstrCount", bus.InstrCount, exp_cnt);
      if (bus.OpCode == 20'h00055) saw55 = 1;
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic load(input int n);
    for (int a = 0; a < n; a++) begin
      bus.ProgWrite = 1; bus.ProgAddr = AW'(a); bus.ProgData = prog[a];
      tick();
    end
    bus.ProgWrite = 0;
  endtask

  // Stray store writes while a program runs; the model assumes they are dropped.
  task automatic scribble();
    bus.ProgWrite = ($urandom_range(0, 3) == 0);
    bus.ProgAddr  = AW'($urandom);
    bus.ProgData  = OPW'($urandom);
  endtask

  task automatic run(input int L, input int stop_at, input int stop_ph,
                     input int acc_lo, input int acc_hi, input int exe_lo, input int exe_hi);
    int len, d, n, e, m;
    bit pend;
    logic [OPW-1:0] w;
    len = (L > DEPTH) ? DEPTH : L;
    bus.ProgLength = (AW+1)'(L);
    bus.Start = 1;
    tick();
    bus.Start = 0;
    exp_pc = 0; exp_cnt = 0; exp_err = 0; exp_op = '0; pend = 0;
    if (len == 0) begin exp_run = 0; exp_halt = 1; return; end
    exp_run = 1; exp_halt = 0;
    forever begin
      bus.Stop = (stop_at == exp_pc && stop_ph == 0);
      tick();
      pend |= bus.Stop; bus.Stop = 0;
      tick();
      w = prog[exp_pc];
      if (w == '0) begin exp_run = 0; exp_halt = 1; return; end
      exp_op = w;
      d = $urandom_range(acc_lo, acc_hi);
      n = 0;
      forever begin
        bus.ExecDone = (n < d);
        bus.Stop = (stop_at == exp_pc && stop_ph == 1 && n == 0);
        scribble();
        tick();
        pend |= bus.Stop; bus.Stop = 0; bus.ProgWrite = 0;
        n++;
        if (!bus.ExecDone) break;
        if (n == TIMEOUT) begin
          exp_err = 1; exp_op = '0; exp_run = 0; exp_halt = 1;
          return;
        end
      end
      e = $urandom_range(exe_lo, exe_hi);
      m = 0;
      forever begin
        bus.ExecDone = (m >= e);
        bus.Stop = (stop_at == exp_pc && stop_ph == 2 && m == 0);
        scribble();
        tick();
        pend |= bus.Stop; bus.Stop = 0; bus.ProgWrite = 0;
        if (bus.ExecDone) break;
        m++;
      end
      exp_pc++;
      if (exp_cnt < 65535) exp_cnt++;
      exp_op = '0;
      if (pend || exp_pc == len) begin exp_run = 0; exp_halt = 1; return; end
`ifdef STEP_EN
      if (step_mode) begin
        repeat ($urandom_range(1, 3)) tick();
        bus.Step = 1;
        tick();
        bus.Step = 0;
      end
`endif
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Start = 0; bus.Stop = 0; bus.ProgWrite = 0; bus.ProgAddr = '0;
    bus.ProgData = '0; bus.ProgLength = '0; bus.ExecDone = 1;
`ifdef STEP_EN
    bus.StepMode = 0; bus.Step = 0;
`endif
    exp_op = '0; exp_pc = 0; exp_cnt = 0; exp_run = 0; exp_halt = 0; exp_err = 0;
    Reset = 1;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_OpCode", bus.OpCode, 0);
    chk("rst_Pc", bus.Pc, 0);
    chk("rst_Running", bus.Running, 0);
    chk("rst_Halted", bus.Halted, 0);
    chk("rst_Error", bus.Error, 0);
    chk("rst_InstrCount", bus.InstrCount, 0);
    Reset = 0;
    chk_en = 1;
    tick();

    // Three-instruction program runs to its length.
    prog[0] = 20'h00011; prog[1] = 20'h00022; prog[2] = 20'h00033;
    load(3);
    run(3, -1, 0, 0, 0, 2, 2);
    tick();
    chk("t1_Pc", bus.Pc, 3);
    chk("t1_InstrCount", bus.InstrCount, 3);
    chk("t1_Halted", bus.Halted, 1);
    chk("t1_Error", bus.Error, 0);

    // End opcode stops the program; the word after it is never issued.
    prog[1] = 20'h00000; prog[2] = 20'h00055;
    load(3);
    saw55 = 0;
    run(3, -1, 0, 0, 2, 0, 2);
    tick();
    chk("t2_Pc", bus.Pc, 1);
    chk("t2_InstrCount", bus.InstrCount, 1);
    chk("t2_no_00055", saw55, 0);

    // Executor never accepts: timeout after exactly TIMEOUT ISSUE cycles.
    prog[0] = 20'h00077;
    load(1);
    run(1, -1, 0, 300, 300, 0, 0);
    tick();
    chk("t3_Error", bus.Error, 1);
    chk("t3_Halted", bus.Halted, 1);
    chk("t3_OpCode", bus.OpCode, 0);
    run(1, -1, 0, 0, 1, 0, 1);
    tick();
    chk("t3_Error_cleared", bus.Error, 0);

    // Stop during EXEC of instruction 0 lets it finish, then halts.
    prog[0] = 20'h00011; prog[1] = 20'h00022; prog[2] = 20'h00033;
    load(3);
    run(3, 0, 2, 0, 0, 3, 3);
    tick();
    chk("t4_Pc", bus.Pc, 1);
    chk("t4_InstrCount", bus.InstrCount, 1);

    // Asynchronous reset while in ISSUE.
    chk_en = 0;
    bus.ExecDone = 1; bus.ProgLength = 6'd3; bus.Start = 1;
    tick();
    bus.Start = 0;
    tick(); tick();
    chk("t5_pre_OpCode", bus.OpCode, 20'h00011);
    #2 Reset = 1;
    #1;
    chk("t5_async_OpCode", bus.OpCode, 0);
    chk("t5_async_Running", bus.Running, 0);
    chk("t5_async_Pc", bus.Pc, 0);
    @(posedge Clock); #1;
    Reset = 0;
    exp_op = '0; exp_pc = 0; exp_cnt = 0; exp_run = 0; exp_halt = 0; exp_err = 0;
    chk_en = 1;
    tick();
    // Rerun without reloading: stray writes issued during the earlier runs must not have landed.
    run(3, -1, 0, 0, 3, 0, 3);
    tick();
    chk("t5_rerun_InstrCount", bus.InstrCount, 3);

`ifdef STEP_EN
    prog[0] = 20'h00101; prog[1] = 20'h00202;
    load(2);
    step_mode = 1; bus.StepMode = 1;
    run(2, -1, 0, 0, 2, 0, 2);
    step_mode = 0; bus.StepMode = 0;
    tick();
    chk("t6_Pc", bus.Pc, 2);
    chk("t6_InstrCount", bus.InstrCount, 2);
`endif

    // Randomized programs, lengths (incl. 0 and clamped), Stop placement and timing.
    for (int r = 0; r < 30; r++) begin
      for (int a = 0; a < DEPTH; a++)
        prog[a] = ($urandom_range(0, 7) == 0) ? '0 : OPW'($urandom_range(1, 20'hFFFFF));
      load(DEPTH);
      run($urandom_range(0, 40), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : -1,
          $urandom_range(0, 2), 0, 3, 0, 3);
      repeat (2) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
